// File: rtl/alu_bist_pkg.sv
// alu_bist_pkg: shared state encoding, MISR constants and the MISR next-state helper
package alu_bist_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam logic [15:0] MISR_POLY = 16'h1021;
  localparam int NUM_VECTORS = 2048;
  localparam int RESP_W = 7;
  function automatic logic [15:0] misr_next(input logic [15:0] s, input logic [RESP_W-1:0] d);
    return {s[14:0], 1'b0} ^ (s[15] ? MISR_POLY : 16'h0) ^ {{(16-RESP_W){1'b0}}, d};
  endfunction
endpackage

// File: rtl/alu_bist_if.sv
// alu_bist_if: ALU-under-test bus; master drives opcode_o/a_o/b_o, slave returns result_i and zf_i/cf_i/pf_i
interface alu_bist_if;
  logic [2:0] opcode_o;
  logic [3:0] a_o, b_o, result_i;
  logic zf_i, cf_i, pf_i;
  modport master(output opcode_o, a_o, b_o, input result_i, zf_i, cf_i, pf_i);
  modport slave(input opcode_o, a_o, b_o, output result_i, zf_i, cf_i, pf_i);
endinterface

// File: rtl/alu_bist_misr.sv
// misr16: 16-bit MISR; ports clk, rst_n (sync, loads seed), load (loads seed), seed, en (absorbs din), din, sig
module misr16
  import alu_bist_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [15:0]       seed,
  input  logic              en,
  input  logic [RESP_W-1:0] din,
  output logic [15:0]       sig
);
  always_ff @(posedge clk)
    sig <= (!rst_n || load) ? seed : en ? misr_next(sig, din) : sig;
endmodule

// File: rtl/alu_bist_ctrl.sv
// alu_bist_ctrl: exhaustive ALU BIST sweep; ports clk, rst_n, start, abort, alu (bus master), busy, done, pass, signature, vec_count
module alu_bist_ctrl
  import alu_bist_pkg::*;
#(
  parameter logic [15:0] GOLDEN_SIG = 16'h0000,
  parameter logic [15:0] SEED       = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  alu_bist_if.master        alu,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       signature,
  output logic [11:0]       vec_count
);
  state_t      state;
  logic [10:0] idx;
  logic        go, absorb;
  assign go = state != RUN && start;
  assign absorb = state == RUN && !abort;
  assign {alu.opcode_o, alu.a_o, alu.b_o} = busy ? idx : 11'd0;
  assign pass = done && signature == GOLDEN_SIG;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      vec_count <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (go) begin
      state <= RUN;
      idx <= '0;
      vec_count <= '0;
      busy <= 1'b1;
      done <= 1'b0;
    end else if (state == RUN) begin
      if (abort) begin
        state <= IDLE;
        busy <= 1'b0;
      end else begin
        idx <= idx + 11'd1;
        vec_count <= vec_count + 12'd1;
        if (idx == 11'(NUM_VECTORS - 1)) begin
          state <= DONE;
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end
  misr16 u_misr (
    .clk  (clk),
    .rst_n(rst_n),
    .load (go),
    .seed (SEED),
    .en   (absorb),
    .din  ({alu.result_i, alu.zf_i, alu.cf_i, alu.pf_i}),
    .sig  (signature)
  );
endmodule

// File: tb/tb_alu_bist_ctrl.sv
// tb_alu_bist_ctrl: scoreboard bench for alu_bist_ctrl; sweep results checked whenever busy drops
module tb_alu_bist_ctrl;
  function automatic logic [15:0] gold_stub();
    logic [15:0] s;
    s = 16'hFFFF;
    for (int o = 0; o < 32; o++)
      for (int i = 0; i < 64; i++)
        s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0);
    return s;
  endfunction
  localparam logic [15:0] GOLD = gold_stub();

  function automatic logic [6:0] alu_fn(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] t;
    case (op)
      3'd0: t = {1'b0, a} + {1'b0, b};
      3'd1: t = {1'b0, a} - {1'b0, b};
      3'd2: t = {1'b0, a & b};
      3'd3: t = {1'b0, a | b};
      3'd4: t = {1'b0, a ^ b};
      3'd5: t = {1'b0, ~a};
      3'd6: t = {a, 1'b0};
      default: t = {a[0], 1'b0, a[3:1]};
    endcase
    return {t[3:0], t[3:0] == 4'd0, t[4], ^t[3:0]};
  endfunction

  function automatic logic [15:0] ref_sig(input bit real_alu, input int n);
    logic [15:0] s;
    logic [10:0] i;
    s = 16'hFFFF;
    for (int j = 0; j < n; j++) begin
      i = j[10:0];
      s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0) ^
          {9'b0, real_alu ? alu_fn(i[10:8], i[7:4], i[3:0]) : 7'd0};
    end
    return s;
  endfunction

  typedef struct packed {
    logic [15:0] sig;
    logic [11:0] vc;
    logic        done;
    logic        pass;
  } exp_t;

  logic clk = 0, rst_n = 0, start = 0, abort = 0, alu_real = 0;
  logic busy, done, pass, b_busy, b_done, b_pass;
  logic [15:0] signature, b_sig;
  logic [11:0] vec_count, b_vc;
  int n_pass = 0, n_total = 0;
  exp_t sb[$];
  logic [15:0] real_full;

  alu_bist_if bus ();
  alu_bist_if bus_b ();

  always #5 clk = ~clk;

  always_comb {bus.result_i, bus.zf_i, bus.cf_i, bus.pf_i} =
    alu_real ? alu_fn(bus.opcode_o, bus.a_o, bus.b_o) : 7'd0;
  assign {bus_b.result_i, bus_b.zf_i, bus_b.cf_i, bus_b.pf_i} = 7'd0;

  alu_bist_ctrl #(.GOLDEN_SIG(GOLD), .SEED(16'hFFFF)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .alu(bus),
    .busy(busy), .done(done), .pass(pass), .signature(signature), .vec_count(vec_count)
  );
  alu_bist_ctrl #(.GOLDEN_SIG(GOLD ^ 16'h0001), .SEED(16'hFFFF)) dut_bad (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .alu(bus_b),
    .busy(b_busy), .done(b_done), .pass(b_pass), .signature(b_sig), .vec_count(b_vc)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
  endtask

  task automatic wait_vc(input logic [11:0] v);
    int k = 0;
    while (!(busy && vec_count == v) && k < 5000) begin
      @(negedge clk);
      k++;
    end
    chk("wait_vc_timeout", 32'(k < 5000), 1);
  endtask

  task automatic wait_done();
    int k = 0;
    while (!done && k < 5000) begin
      @(negedge clk);
      k++;
    end
    chk("wait_done_timeout", 32'(k < 5000), 1);
  endtask

  task automatic chk_zero_vec(input string nm);
    chk(nm, {21'd0, bus.opcode_o, bus.a_o, bus.b_o}, 0);
  endtask

  initial begin
    logic bp;
    exp_t e;
    bp = 0;
    forever begin
      @(negedge clk);
      if (bp && !busy) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL sb_unexpected_end: got busy drop expected none at %0t", $time);
        end else begin
          e = sb.pop_front();
          chk("sb_signature", signature, e.sig);
          chk("sb_vec_count", vec_count, e.vc);
          chk("sb_done", done, e.done);
          chk("sb_pass", pass, e.pass);
        end
      end
      bp = busy;
    end
  end

  initial begin
    int n, k;
    logic first_ok, last_ok;
    real_full = ref_sig(1, 2048);
    repeat (3) @(negedge clk);
    rst_n = 1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_sig", signature, 16'hFFFF);
    chk("rst_vc", vec_count, 0);
    chk_zero_vec("rst_vec");

    sb.push_back('{sig: ref_sig(0, 2048), vc: 12'd2048, done: 1'b1, pass: 1'b1});
    pulse_start();
    chk("start_busy", busy, 1);
    n = 0; k = 0; first_ok = 0; last_ok = 0;
    while (!done && k < 3000) begin
      if (busy) n++;
      if (busy && vec_count == 0) first_ok = {bus.opcode_o, bus.a_o, bus.b_o} == 11'h000;
      if (busy && vec_count == 2047) last_ok = {bus.opcode_o, bus.a_o, bus.b_o} == 11'h7FF;
      @(negedge clk);
      k++;
    end
    chk("busy_cycles", n, 2048);
    chk("first_vec", first_ok, 1);
    chk("last_vec", last_ok, 1);
    chk("done_vec_zero", {21'd0, bus.opcode_o, bus.a_o, bus.b_o}, 0);
    chk("bad_done", b_done, 1);
    chk("bad_pass", b_pass, 0);

    alu_real = 1;
    sb.push_back('{sig: ref_sig(1, 100), vc: 12'd100, done: 1'b0, pass: 1'b0});
    pulse_start();
    wait_vc(100);
    chk("pre_abort_vec", {21'd0, bus.opcode_o, bus.a_o, bus.b_o}, 32'h064);
    abort = 1;
    @(negedge clk) abort = 0;
    chk("abort_busy", busy, 0);
    chk_zero_vec("abort_vec");
    repeat (3) @(negedge clk);
    chk("abort_no_done", done, 0);

    sb.push_back('{sig: 16'hFFFF, vc: 12'd0, done: 1'b0, pass: 1'b0});
    pulse_start();
    wait_vc(1500);
    rst_n = 0;
    @(negedge clk) rst_n = 1;
    chk_zero_vec("reset_vec");
    sb.push_back('{sig: real_full, vc: 12'd2048, done: 1'b1, pass: 1'b0});
    pulse_start();
    wait_done();

    sb.push_back('{sig: real_full, vc: 12'd2048, done: 1'b1, pass: 1'b0});
    sb.push_back('{sig: real_full, vc: 12'd2048, done: 1'b1, pass: 1'b0});
    @(negedge clk) start = 1;
    @(negedge clk);
    wait_vc(500);
    @(negedge clk);
    chk("held_start_vc", vec_count, 501);
    wait_done();
    @(negedge clk);
    chk("restart_busy", busy, 1);
    chk("restart_vc", vec_count, 0);
    chk("restart_sig", signature, 16'hFFFF);
    @(negedge clk);
    wait_done();
    start = 0;
    @(negedge clk);
    chk("held_stays_done", done, 1);

    sb.push_back('{sig: real_full, vc: 12'd2048, done: 1'b1, pass: 1'b0});
    start = 1;
    abort = 1;
    @(negedge clk);
    start = 0;
    abort = 0;
    chk("sa_busy", busy, 1);
    chk("sa_sig", signature, 16'hFFFF);
    chk("sa_vc", vec_count, 0);
    wait_done();
    @(negedge clk);
    n_total++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL sb_leftover: got %0d pending expected 0", sb.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/alu_bist_ctrl.md
ALU_BIST_CTRL -- requirements
Module: alu_bist_ctrl

Interface
REQ-001 Parameter GOLDEN_SIG, default 16'h0000, expected final signature for pass/fail.
REQ-002 Parameter SEED, default 16'hFFFF, signature register start value.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 start  input  1  level sampled each cycle; a high sample in IDLE or DONE begins a sweep.
REQ-006 abort  input  1  high sample terminates a running sweep.
REQ-007 opcode_o  output  3  opcode driven to the ALU under test.
REQ-008 a_o  output  4  operand A driven to the ALU (two's-complement bit pattern).
REQ-009 b_o  output  4  operand B driven to the ALU.
REQ-010 result_i  input  4  ALU result.
REQ-011 zf_i, cf_i, pf_i  input  1 each  ALU zero, carry and parity flags.
REQ-012 busy  output  1  high while a sweep runs.
REQ-013 done  output  1  high while in DONE.
REQ-014 pass  output  1  done and signature == GOLDEN_SIG.
REQ-015 signature  output  16  MISR contents.
REQ-016 vec_count  output  12  number of vectors absorbed in the current or last sweep (0..2048).

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-018 Transitions: IDLE->RUN on start; RUN->DONE after the 2048th absorb; RUN->IDLE on abort; DONE->RUN on start; all other cases hold state.
REQ-019 The vector index SHALL be an 11-bit counter {opcode,A,B}; opcode_o=idx[10:8], a_o=idx[7:4], b_o=idx[3:0] (B innermost, opcode outermost).
REQ-020 Entering RUN SHALL clear idx and vec_count to 0 and load signature with SEED on the same edge.
REQ-021 In every RUN cycle, the ALU is combinational and its inputs are the current outputs; on the next edge the MISR SHALL absorb resp={result_i,zf_i,cf_i,pf_i} (7 bits).
REQ-022 On that same edge, idx SHALL increment and vec_count SHALL increment.
REQ-023 MISR update: sig <= {sig[14:0],1'b0} ^ (sig[15] ? 16'h1021 : 16'h0) ^ {9'b0,resp}.
REQ-024 When idx==11'h7FF and an absorb occurs, the FSM SHALL enter DONE and idx SHALL wrap to 0.
REQ-025 In DONE, vec_count SHALL read 2048 and signature SHALL be frozen.
REQ-026 A sweep SHALL therefore take exactly 2048 RUN cycles, with done high on cycle 2049 after the start sample.
REQ-027 opcode_o, a_o and b_o SHALL be 0 in IDLE and DONE.
REQ-028 start while in RUN SHALL be ignored.
REQ-029 abort in RUN SHALL win over the final absorb: the edge goes to IDLE with no absorb, and signature and vec_count hold their partial values.
REQ-030 abort outside RUN SHALL be ignored.
REQ-031 If start and abort are both high in IDLE or DONE, start SHALL win.
REQ-032 busy SHALL be 1 exactly in RUN.
REQ-033 pass SHALL be combinational from the registered done and signature values.

Reset
REQ-034 With rst_n low at an edge, the FSM SHALL go to IDLE, with idx=0, vec_count=0, signature=SEED, busy=0, done=0 and pass=0.
REQ-035 Reset mid-sweep SHALL discard all progress; no partial done is produced.
REQ-036 Reset SHALL dominate start and abort.

Structure
REQ-037 Package alu_bist_pkg SHALL hold the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2), MISR_POLY=16'h1021, NUM_VECTORS=2048 and RESP_W=7.
REQ-038 The MISR SHALL be a sub-module, misr16 (clk, rst_n, load, seed, en, din[6:0], sig[15:0]).
REQ-039 The FSM and the counter SHALL live in alu_bist_ctrl.

Verification
REQ-040 Reset, then pulse start for 1 cycle -> busy rises next edge; the first driven vector is (0,0,0), the last is (7,15,15); done rises after exactly 2048 busy cycles; vec_count=2048.
REQ-041 ALU stub tied to 0, with the bench running a reference MISR model from SEED=FFFF -> signature matches the model; with GOLDEN_SIG set to the model value, pass=1; with GOLDEN_SIG set to model^1, pass=0.
REQ-042 Real ALU, with abort asserted at RUN cycle 100 -> IDLE next edge; vec_count=100; outputs return to 0; done is never asserted.
REQ-043 rst_n low at RUN cycle 1500 -> IDLE with signature=FFFF and vec_count=0; a following start completes a full 2048-vector sweep whose signature matches an uninterrupted run.
REQ-044 Start held high continuously -> the sweep runs once; at DONE it restarts on the next cycle (DONE->RUN); start pulses during RUN do not reset idx.
REQ-045 start and abort high together in DONE -> a new sweep starts; signature reloads to SEED.
